// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS pipeline datapath and the stall/flush sequencer.
// The datapath side (master) reports ID/EX hazard sources; the controller (slave) returns stage controls.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_reads_hilo;
    logic       ex_mem_read;
    logic [4:0] ex_rw;
    logic       ex_md_start;
    logic       ex_md_is_div;
    logic       exception;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       idex_bubble;
    logic       exmem_bubble;
    logic       flush_ifid;
    logic       flush_idex;
    logic       flush_exmem;
    logic       md_busy;
    logic       md_done;
    logic       md_abort;
    // Debug view of the controller FSM: 0=IDLE, 1=MD_BUSY, 2=FLUSH.
    logic [1:0] dbg_state;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_reads_hilo,
               ex_mem_read, ex_rw, ex_md_start, ex_md_is_div, exception,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               idex_bubble, exmem_bubble, flush_ifid, flush_idex, flush_exmem,
               md_busy, md_done, md_abort, dbg_state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_reads_hilo,
               ex_mem_read, ex_rw, ex_md_start, ex_md_is_div, exception,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               idex_bubble, exmem_bubble, flush_ifid, flush_idex, flush_exmem,
               md_busy, md_done, md_abort, dbg_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls,
// HI/LO mul/div occupancy tracking and the two-cycle exception/ERET flush.
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int MUL_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rset,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    // Counter is loaded with N-2 so md_done lands N-1 cycles after the issue cycle.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       md_busy_q, md_busy_d;

    logic load_use;
    logic md_hazard;
    logic pc_en, ifid_en, idex_en;
    logic idex_bubble, exmem_bubble;
    logic flush_ifid, flush_idex, flush_exmem;
    logic md_done, md_abort;

    assign load_use = hz.ex_mem_read & (hz.ex_rw != 5'd0) &
                      ((hz.id_use_rs & (hz.id_rs == hz.ex_rw)) |
                       (hz.id_use_rt & (hz.id_rt == hz.ex_rw)));
    assign md_hazard = hz.id_reads_hilo | hz.ex_md_start;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;
        md_done      = 1'b0;
        md_abort     = 1'b0;

        if (!rset) begin
            if (hz.exception) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
                md_abort    = (state_q == MD_BUSY);
                state_d     = FLUSH;
                cnt_d       = 6'd0;
            end else begin
                unique case (state_q)
                    FLUSH: begin
                        // Second flush cycle kills the fetch of the delay slot.
                        flush_ifid = 1'b1;
                        state_d    = IDLE;
                    end
                    MD_BUSY: begin
                        if (md_hazard) begin
                            pc_en        = 1'b0;
                            ifid_en      = 1'b0;
                            idex_en      = 1'b0;
                            exmem_bubble = 1'b1;
                        end else if (load_use) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_bubble = 1'b1;
                        end
                        if (cnt_q == 6'd0) begin
                            md_done = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 6'd1;
                        end
                    end
                    default: begin
                        if (load_use) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_bubble = 1'b1;
                        end
                        if (hz.ex_md_start) begin
                            cnt_d   = hz.ex_md_is_div ? DIV_LOAD : MUL_LOAD;
                            state_d = MD_BUSY;
                        end
                    end
                endcase
            end
        end
    end

    assign md_busy_d = (state_d == MD_BUSY);

    always_ff @(posedge clk) begin
        if (rset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.idex_en      = idex_en;
    // Reserved for future memory wait states; never deasserted in this revision.
    assign hz.exmem_en     = 1'b1;
    assign hz.memwb_en     = 1'b1;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.flush_ifid   = flush_ifid;
    assign hz.flush_idex   = flush_idex;
    assign hz.flush_exmem  = flush_exmem;
    assign hz.md_busy      = md_busy_q;
    assign hz.md_done      = md_done;
    assign hz.md_abort     = md_abort;
    assign hz.dbg_state    = state_q;
endmodule
